// File: rtl/writeback_stage.sv
// Writeback stage: registers instructions leaving MEM, waits for late load data,
// and commits one register-file / PC write per retired instruction.
// Latency: commit is visible one cycle after capture (or one cycle after late load data).
// Backpressure: o_Stall_W is high only while waiting for load data; nothing is captured then.
//
// Ports:
//   i_clk, i_reset (sync, active-low)
//   MEM side  : i_valid_M, i_RegWrite_M, i_MemtoReg_M, i_PCSrc_M, i_WA3_M, i_ALUResult_M, i_Flush_W
//   DMEM side : i_ReadData_valid, i_ReadData
//   RF/PC side: o_Result_W, o_WA3_W, o_RegWrite_W, o_PCSrc_W
//   Status    : o_Stall_W, o_LoadFault, o_Retired
module writeback_stage #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid_M,
  input  logic        i_RegWrite_M,
  input  logic        i_MemtoReg_M,
  input  logic        i_PCSrc_M,
  input  logic [3:0]  i_WA3_M,
  input  logic [31:0] i_ALUResult_M,
  input  logic        i_Flush_W,
  input  logic        i_ReadData_valid,
  input  logic [31:0] i_ReadData,
  output logic [31:0] o_Result_W,
  output logic [3:0]  o_WA3_W,
  output logic        o_RegWrite_W,
  output logic        o_PCSrc_W,
  output logic        o_Stall_W,
  output logic        o_LoadFault,
  output logic [31:0] o_Retired
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LOAD = 2'd1,
    S_COMMIT    = 2'd2
  } state_t;

  // Last counter value tolerated before the load is declared lost.
  localparam logic [7:0] CNT_LAST = 8'(LOAD_TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  // Fields of a load parked in WAIT_LOAD; the result comes from memory.
  logic        r_regwrite_l;
  logic        r_pcsrc_l;
  logic [3:0]  r_wa3_l;
  // Committed (output) registers.
  logic [31:0] r_result;
  logic [3:0]  r_wa3;
  logic        r_regwrite;
  logic        r_pcsrc;
  logic        r_fault;
  logic [31:0] r_retired;

  logic w_capture;
  logic w_commit_now;

  // Capture is possible whenever no load is outstanding.
  assign w_capture    = (r_state != S_WAIT_LOAD) && i_valid_M && !i_Flush_W;
  // A captured instruction commits immediately unless it is a load without data.
  assign w_commit_now = !i_MemtoReg_M || i_ReadData_valid;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_regwrite_l <= 1'b0;
      r_pcsrc_l    <= 1'b0;
      r_wa3_l      <= 4'd0;
      r_result     <= 32'd0;
      r_wa3        <= 4'd0;
      r_regwrite   <= 1'b0;
      r_pcsrc      <= 1'b0;
      r_fault      <= 1'b0;
      r_retired    <= 32'd0;
    end else begin
      // Write strobes and the fault flag are single-cycle pulses.
      r_regwrite <= 1'b0;
      r_pcsrc    <= 1'b0;
      r_fault    <= 1'b0;

      // The instruction retires at the edge that ends its commit cycle.
      if (r_state == S_COMMIT) begin
        r_retired <= r_retired + 32'd1;
      end

      case (r_state)
        S_WAIT_LOAD: begin
          if (i_Flush_W) begin
            r_state <= S_IDLE;
          end else if (i_ReadData_valid) begin
            r_result   <= i_ReadData;
            r_wa3      <= r_wa3_l;
            r_regwrite <= r_regwrite_l;
            r_pcsrc    <= r_pcsrc_l & r_regwrite_l;
            r_state    <= S_COMMIT;
          end else if (r_cnt == CNT_LAST) begin
            r_fault <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          if (w_capture) begin
            r_regwrite_l <= i_RegWrite_M;
            r_pcsrc_l    <= i_PCSrc_M;
            r_wa3_l      <= i_WA3_M;
            if (w_commit_now) begin
              r_result   <= i_MemtoReg_M ? i_ReadData : i_ALUResult_M;
              r_wa3      <= i_WA3_M;
              r_regwrite <= i_RegWrite_M;
              r_pcsrc    <= i_PCSrc_M & i_RegWrite_M;
              r_state    <= S_COMMIT;
            end else begin
              r_cnt   <= 8'd0;
              r_state <= S_WAIT_LOAD;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign o_Result_W   = r_result;
  assign o_WA3_W      = r_wa3;
  assign o_RegWrite_W = r_regwrite;
  assign o_PCSrc_W    = r_pcsrc;
  assign o_Stall_W    = (r_state == S_WAIT_LOAD);
  assign o_LoadFault  = r_fault;
  assign o_Retired    = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: scoreboard of expected register writes (with the
// cycle each must appear in), plus per-phase counts of stall, fault and PC-write cycles.
module tb_writeback_stage;

  localparam int T = 4;

  logic        clk;
  logic        rst_n;
  logic        valid_m, regwrite_m, memtoreg_m, pcsrc_m, flush_w, rd_vld;
  logic [3:0]  wa3_m;
  logic [31:0] alu_m, rd_dat;
  logic [31:0] result_w, retired;
  logic [3:0]  wa3_w;
  logic        regwrite_w, pcsrc_w, stall_w, fault;

  writeback_stage #(.LOAD_TIMEOUT(T)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_valid_M(valid_m), .i_RegWrite_M(regwrite_m), .i_MemtoReg_M(memtoreg_m),
    .i_PCSrc_M(pcsrc_m), .i_WA3_M(wa3_m), .i_ALUResult_M(alu_m),
    .i_Flush_W(flush_w), .i_ReadData_valid(rd_vld), .i_ReadData(rd_dat),
    .o_Result_W(result_w), .o_WA3_W(wa3_w), .o_RegWrite_W(regwrite_w),
    .o_PCSrc_W(pcsrc_w), .o_Stall_W(stall_w), .o_LoadFault(fault), .o_Retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wa3;
    logic [31:0] res;
    logic        pcs;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stall_cnt, fault_cnt, pcs_cnt, wr_cnt, fault_cyc;
  int          wr_cyc[$];
  logic [31:0] exp_ret = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    stall_cnt = 0; fault_cnt = 0; pcs_cnt = 0; wr_cnt = 0; fault_cyc = -1;
    wr_cyc.delete();
  endtask

  // Observe the current cycle at the falling edge, then advance one clock.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (regwrite_w) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(wa3_w), 64'hFF);
      end else begin
        e = sb.pop_front();
        check("wa3", 64'(wa3_w), 64'(e.wa3));
        check("result", 64'(result_w), 64'(e.res));
        check("pcsrc", 64'(pcsrc_w), 64'(e.pcs));
        check("commit_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (stall_w) stall_cnt++;
    if (pcsrc_w) pcs_cnt++;
    if (fault) begin
      fault_cnt++;
      fault_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic pcs,
                       input logic [3:0] wa3, input logic [31:0] alu, input logic fl,
                       input logic rdv, input logic [31:0] rd);
    valid_m = v; regwrite_m = rw; memtoreg_m = m2r; pcsrc_m = pcs;
    wa3_m = wa3; alu_m = alu; flush_w = fl; rd_vld = rdv; rd_dat = rd;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 4'd0, 32'd0, 0, 0, 32'd0);
  endtask

  task automatic expect_wr(input logic [3:0] wa3, input logic [31:0] res,
                           input logic pcs, input int at);
    exp_t e;
    e.wa3 = wa3; e.res = res; e.pcs = pcs; e.cyc = at;
    sb.push_back(e);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    valid_m = 0; regwrite_m = 0; memtoreg_m = 0; pcsrc_m = 0;
    wa3_m = 0; alu_m = 0; flush_w = 0; rd_vld = 0; rd_dat = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_result", 64'(result_w), 64'd0);
    check("rst_wa3", 64'(wa3_w), 64'd0);
    check("rst_regwrite", 64'(regwrite_w), 64'd0);
    check("rst_pcsrc", 64'(pcsrc_w), 64'd0);
    check("rst_stall", 64'(stall_w), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    rst_n = 1'b1;

    // Three back-to-back ALU instructions.
    clear_counts();
    for (int i = 1; i <= 3; i++) begin
      expect_wr(4'(i), 32'(i * 16), 1'b0, cyc + 1);
      exp_ret++;
      drive(1, 1, 0, 0, 4'(i), 32'(i * 16), 0, 0, 32'd0);
    end
    idle(2);
    check("b2b_writes", 64'(wr_cnt), 64'd3);
    if (wr_cyc.size() == 3) check("b2b_span", 64'(wr_cyc[2] - wr_cyc[0]), 64'd2);
    check("b2b_stall", 64'(stall_cnt), 64'd0);
    check("b2b_retired", 64'(retired), 64'd3);

    // Load whose data is ready in the capture cycle.
    clear_counts();
    expect_wr(4'd4, 32'hDEADBEEF, 1'b0, cyc + 1);
    exp_ret++;
    drive(1, 1, 1, 0, 4'd4, 32'h44, 0, 1, 32'hDEADBEEF);
    idle(2);
    check("ld_ready_stall", 64'(stall_cnt), 64'd0);
    check("ld_ready_writes", 64'(wr_cnt), 64'd1);

    // Stray read data while idle must be ignored.
    drive(0, 0, 0, 0, 4'd0, 32'd0, 0, 1, 32'h55555555);

    // Late load: data three cycles after capture; upstream keeps offering another
    // instruction while stalled, which must not be captured.
    clear_counts();
    base = cyc;
    expect_wr(4'd5, 32'hCAFEF00D, 1'b0, base + 4);
    exp_ret++;
    drive(1, 1, 1, 0, 4'd5, 32'h55, 0, 0, 32'd0);
    drive(1, 1, 0, 0, 4'd11, 32'hBAD, 0, 0, 32'h1111);
    drive(1, 1, 0, 0, 4'd11, 32'hBAD, 0, 0, 32'h2222);
    drive(0, 0, 0, 0, 4'd0, 32'd0, 0, 1, 32'hCAFEF00D);
    idle(2);
    check("late_stall", 64'(stall_cnt), 64'd3);
    check("late_writes", 64'(wr_cnt), 64'd1);
    check("late_retired", 64'(retired), 64'(exp_ret));

    // Load that never gets data.
    clear_counts();
    base = cyc;
    drive(1, 1, 1, 0, 4'd6, 32'h66, 0, 0, 32'd0);
    idle(T + 3);
    check("to_fault_cnt", 64'(fault_cnt), 64'd1);
    check("to_fault_cyc", 64'(fault_cyc), 64'(base + T + 1));
    check("to_stall", 64'(stall_cnt), 64'(T));
    check("to_writes", 64'(wr_cnt), 64'd0);
    check("to_retired", 64'(retired), 64'(exp_ret));
    check("to_idle", 64'(stall_w), 64'd0);
    expect_wr(4'd7, 32'h77, 1'b0, cyc + 1);
    exp_ret++;
    drive(1, 1, 0, 0, 4'd7, 32'h77, 0, 0, 32'd0);
    idle(2);
    check("to_next_retired", 64'(retired), 64'(exp_ret));

    // Flush while waiting, coinciding with data arrival.
    clear_counts();
    drive(1, 1, 1, 0, 4'd8, 32'h88, 0, 0, 32'd0);
    drive(0, 0, 0, 0, 4'd0, 32'd0, 1, 1, 32'h12345678);
    idle(T + 3);
    check("fl_wait_writes", 64'(wr_cnt), 64'd0);
    check("fl_wait_fault", 64'(fault_cnt), 64'd0);
    check("fl_wait_stall", 64'(stall_cnt), 64'd1);
    check("fl_wait_retired", 64'(retired), 64'(exp_ret));

    // Flush during a commit: the commit finishes, the incoming instruction dies.
    clear_counts();
    expect_wr(4'd9, 32'h99, 1'b0, cyc + 1);
    exp_ret++;
    drive(1, 1, 0, 0, 4'd9, 32'h99, 0, 0, 32'd0);
    drive(1, 1, 0, 0, 4'd10, 32'hAA, 1, 0, 32'd0);
    idle(3);
    check("fl_commit_writes", 64'(wr_cnt), 64'd1);
    check("fl_commit_retired", 64'(retired), 64'(exp_ret));

    // PC writes: only when RegWrite accompanies PCSrc; both retire.
    clear_counts();
    expect_wr(4'd15, 32'h100, 1'b1, cyc + 1);
    exp_ret++;
    drive(1, 1, 0, 1, 4'd15, 32'h100, 0, 0, 32'd0);
    exp_ret++;
    drive(1, 0, 0, 1, 4'd15, 32'h200, 0, 0, 32'd0);
    idle(2);
    check("pc_pulses", 64'(pcs_cnt), 64'd1);
    check("pc_writes", 64'(wr_cnt), 64'd1);
    check("pc_retired", 64'(retired), 64'(exp_ret));

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Writeback stage of the five-stage pipelined core: the producer of the register-file write port and PC-write request that the decode stage consumes. It registers each instruction leaving the memory stage, waits for late load data from the data-memory handshake, selects ALU result or load data, and commits exactly one register write per retired instruction. It also owns load-timeout detection and the retired-instruction counter.

## Interface
- LOAD_TIMEOUT, 16: max cycles spent waiting for load data before faulting (1..255)
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-low reset (asserted when 0)
- i_valid_M  in  1  memory stage presents an instruction this cycle
- i_RegWrite_M  in  1  instruction writes Rd
- i_MemtoReg_M  in  1  result comes from load data
- i_PCSrc_M  in  1  instruction writes PC (Rd = 15)
- i_WA3_M  in  4  destination register
- i_ALUResult_M  in  32  ALU result
- i_Flush_W  in  1  kill instruction being captured and any pending load
- i_ReadData_valid  in  1  load data valid this cycle
- i_ReadData  in  32  load data
- o_Result_W  out  32  value to write to register file
- o_WA3_W  out  4  write address
- o_RegWrite_W  out  1  register write enable (commit cycle only)
- o_PCSrc_W  out  1  PC write request (commit cycle only)
- o_Stall_W  out  1  upstream must hold; no capture this cycle
- o_LoadFault  out  1  one-cycle pulse on load timeout
- o_Retired  out  32  retired-instruction count

## Operation
- States: IDLE, WAIT_LOAD, COMMIT. o_Stall_W = 1 exactly when state is WAIT_LOAD (registered, no input path).
- Capture: in IDLE or COMMIT, if i_valid_M=1 and i_Flush_W=0, latch RegWrite, MemtoReg, PCSrc, WA3, ALUResult.
  - Non-load (MemtoReg=0): next state COMMIT, result = ALUResult.
  - Load with i_ReadData_valid=1 same cycle: latch i_ReadData, next state COMMIT.
  - Load with i_ReadData_valid=0: next state WAIT_LOAD, timeout counter cleared to 0.
- No capture in IDLE/COMMIT: next state IDLE.
- WAIT_LOAD: i_ReadData_valid=1 → latch data, next COMMIT. Else counter++; when counter reaches LOAD_TIMEOUT-1 with no data → pulse o_LoadFault next cycle, no write, no retire, next IDLE.
- i_Flush_W=1 in WAIT_LOAD: abandon load, no write, no retire, no fault, next IDLE; flush wins over simultaneous i_ReadData_valid.
- i_Flush_W=1 in COMMIT: current commit still completes; incoming instruction dropped.
- COMMIT: o_RegWrite_W = latched RegWrite, o_PCSrc_W = latched PCSrc & latched RegWrite, o_Result_W/o_WA3_W = latched values; o_Retired increments by 1 (wraps 0xFFFFFFFF → 0), regardless of RegWrite.
- In IDLE/WAIT_LOAD: o_RegWrite_W=0, o_PCSrc_W=0; o_Result_W/o_WA3_W hold last committed values.
- i_ReadData_valid outside WAIT_LOAD and not coinciding with a load capture: ignored.

## Timing
- Reset (i_reset=0 at edge): state IDLE, all outputs 0, o_Retired=0, counter 0, latched fields 0. Reset mid-WAIT_LOAD drops the load silently.
- Latency: non-load or ready load captured at edge N → commit visible during cycle N+1 (one cycle).
- Late load: data valid at edge N+k → commit in cycle N+k+1; o_Stall_W high from cycle N+1 through cycle N+k inclusive.
- Throughput: one instruction per cycle with back-to-back non-stalling captures (COMMIT → COMMIT).
- Timeout: load captured at edge N, no data → o_LoadFault high during cycle N+LOAD_TIMEOUT+1, state IDLE same cycle.
- o_Retired updates at the edge ending the COMMIT cycle.

## Test plan
- Reset then three back-to-back non-loads (WA3=1,2,3; ALUResult=0x10,0x20,0x30, RegWrite=1) → o_RegWrite_W high three consecutive cycles with matching WA3/Result, o_Stall_W never high, o_Retired=3.
- Load WA3=4, data 0xDEADBEEF valid in capture cycle → commit next cycle, Result=0xDEADBEEF, no stall.
- Load WA3=5, data valid 3 cycles later (0xCAFEF00D) → o_Stall_W high 3 cycles, commit Result=0xCAFEF00D following cycle, o_Retired +1.
- LOAD_TIMEOUT=4, load with no data → o_LoadFault pulses once, no register write, o_Retired unchanged, state IDLE; subsequent non-load commits normally.
- Flush in WAIT_LOAD coinciding with i_ReadData_valid → no write, no fault, no retire; flush during COMMIT with new i_valid_M → current commit occurs, new instruction never commits.
- Instruction with PCSrc=1, RegWrite=1, WA3=15, Result=0x100 → o_PCSrc_W and o_RegWrite_W high in commit cycle; same with RegWrite=0 → o_PCSrc_W stays 0; preload o_Retired near 0xFFFFFFFF via commits-count check of wrap to 0.
